// File: rtl/motor_pkg.sv
// Shared types and encodings for the two-wheel PWM motor drive.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BRAKE = 2'd2
  } state_t;

  localparam logic [3:0] DIR_FWD   = 4'b0000;
  localparam logic [3:0] DIR_LEFT  = 4'b0101;
  localparam logic [3:0] DIR_RIGHT = 4'b1001;
  localparam logic [3:0] DIR_STOP  = 4'b1111;

  localparam logic [1:0] PIN_FWD   = 2'b10;
  localparam logic [1:0] PIN_BRAKE = 2'b11;
  localparam logic [1:0] PIN_COAST = 2'b00;

  // Anything that is not one of the three drive codes is a stop request.
  function automatic logic is_drive(input logic [3:0] d);
    case (d)
      DIR_FWD, DIR_LEFT, DIR_RIGHT: return 1'b1;
      DIR_STOP:                     return 1'b0;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One wheel: slew-limited duty register stepped at period wrap, registered PWM compare.
module pwm_channel #(
  parameter int PWM_PERIOD = 1000,
  parameter int RAMP_STEP  = 50,
  parameter int DW         = $clog2(PWM_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] cnt,
  input  logic          wrap,
  input  logic [DW-1:0] target,
  input  logic          force_zero,
  output logic          pwm
);

  localparam logic [DW-1:0] STEP = DW'(RAMP_STEP);

  logic [DW-1:0] duty;
  logic [DW-1:0] duty_next;
  logic [DW:0]   up;
  logic [DW:0]   gap;

  // Extra bit on the up/gap arithmetic so clamping never sees a wrapped value.
  always_comb begin
    up        = {1'b0, duty} + {1'b0, STEP};
    gap       = {1'b0, duty} - {1'b0, target};
    duty_next = duty;
    if (duty < target)
      duty_next = (up > {1'b0, target}) ? target : up[DW-1:0];
    else if (duty > target)
      duty_next = (gap > {1'b0, STEP}) ? (duty - STEP) : target;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else if (force_zero) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      if (wrap)
        duty <= duty_next;
      pwm <= (cnt < duty);
    end
  end

endmodule

// File: rtl/motor_drive_pwm.sv
// Direction-code driven two-wheel H-bridge controller with slew-limited PWM and timed brake.
// state | meaning
// IDLE  | coasting, duties 0, waiting for a drive code
// RUN   | pins forward, duties ramp toward decoded targets
// BRAKE | pins brake, pwm 0, hold for BRAKE_CYCLES then re-evaluate dir_q
module motor_drive_pwm
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD   = 1000,
  parameter int FULL_DUTY    = 1000,
  parameter int SLOW_DUTY    = 400,
  parameter int RAMP_STEP    = 50,
  parameter int BRAKE_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dir,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic [1:0] left_in,
  output logic [1:0] right_in,
  output logic       braking,
  output logic       moving
);

  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam int BW = $clog2(BRAKE_CYCLES + 1);
  localparam logic [DW-1:0] LAST   = DW'(PWM_PERIOD - 1);
  localparam logic [DW-1:0] FULL_T = DW'(FULL_DUTY);
  localparam logic [DW-1:0] SLOW_T = DW'(SLOW_DUTY);

  logic [3:0]    dir_q;
  logic [DW-1:0] cnt;
  logic          wrap;
  logic [BW-1:0] brake_cnt;
  state_t        state;
  logic [1:0]    pins;
  logic          stop_req;
  logic          force_zero;
  logic [DW-1:0] left_target;
  logic [DW-1:0] right_target;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_q <= '0;
      cnt   <= '0;
    end else begin
      dir_q <= dir;
      cnt   <= wrap ? '0 : cnt + DW'(1);
    end
  end

  assign wrap         = (cnt == LAST);
  assign stop_req     = !is_drive(dir_q);
  // A stop seen in RUN zeroes duties on the same edge that enters BRAKE, overriding any wrap step.
  assign force_zero   = (state != RUN) || stop_req;
  assign left_target  = (dir_q == DIR_LEFT)  ? SLOW_T : FULL_T;
  assign right_target = (dir_q == DIR_RIGHT) ? SLOW_T : FULL_T;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pins      <= PIN_COAST;
      braking   <= 1'b0;
      moving    <= 1'b0;
      brake_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!stop_req) begin
            state  <= RUN;
            pins   <= PIN_FWD;
            moving <= 1'b1;
          end
        end
        RUN: begin
          if (stop_req) begin
            state     <= BRAKE;
            pins      <= PIN_BRAKE;
            braking   <= 1'b1;
            moving    <= 1'b0;
            brake_cnt <= BW'(BRAKE_CYCLES - 1);
          end
        end
        BRAKE: begin
          if (brake_cnt != '0) begin
            brake_cnt <= brake_cnt - BW'(1);
          end else if (stop_req) begin
            state   <= IDLE;
            pins    <= PIN_COAST;
            braking <= 1'b0;
          end else begin
            state   <= RUN;
            pins    <= PIN_FWD;
            braking <= 1'b0;
            moving  <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          pins    <= PIN_COAST;
          braking <= 1'b0;
          moving  <= 1'b0;
        end
      endcase
    end
  end

  assign left_in  = pins;
  assign right_in = pins;

  pwm_channel #(.PWM_PERIOD(PWM_PERIOD), .RAMP_STEP(RAMP_STEP), .DW(DW)) u_left (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt        (cnt),
    .wrap       (wrap),
    .target     (left_target),
    .force_zero (force_zero),
    .pwm        (left_pwm)
  );

  pwm_channel #(.PWM_PERIOD(PWM_PERIOD), .RAMP_STEP(RAMP_STEP), .DW(DW)) u_right (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt        (cnt),
    .wrap       (wrap),
    .target     (right_target),
    .force_zero (force_zero),
    .pwm        (right_pwm)
  );

endmodule

// File: tb/tb_motor_drive_pwm.sv
// Scenario bench for motor_drive_pwm with a queue of expected per-period high counts.
module tb_motor_drive_pwm;
  import motor_pkg::*;

  localparam int P    = 10;
  localparam int FULL = 10;
  localparam int SLOW = 4;
  localparam int STEP = 2;
  localparam int BRK  = 5;

  // {left_pwm, right_pwm, left_in, right_in, braking, moving}
  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_RUN0 = 8'b0010_1001;
  localparam logic [7:0] O_RUN1 = 8'b1110_1001;
  localparam logic [7:0] O_BRK  = 8'b0011_1110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dir = DIR_FWD;
  logic       left_pwm, right_pwm, braking, moving;
  logic [1:0] left_in, right_in;

  int total = 0;
  int bad = 0;
  int tb_cnt = 0;

  typedef struct {
    int l;
    int r;
  } exp_t;
  exp_t exp_q[$];

  wire [7:0] obs = {left_pwm, right_pwm, left_in, right_in, braking, moving};

  motor_drive_pwm #(
    .PWM_PERIOD(P), .FULL_DUTY(FULL), .SLOW_DUTY(SLOW), .RAMP_STEP(STEP), .BRAKE_CYCLES(BRK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dir(dir),
    .left_pwm(left_pwm), .right_pwm(right_pwm),
    .left_in(left_in), .right_in(right_in),
    .braking(braking), .moving(moving)
  );

  always #5 clk = ~clk;

  // Free-running period timebase: value the period counter holds after each edge.
  always @(posedge clk) begin
    if (!rst_n) tb_cnt <= 0;
    else        tb_cnt <= (tb_cnt == P - 1) ? 0 : tb_cnt + 1;
  end

  task automatic push_win(input int l, input int r);
    exp_t e;
    e.l = l;
    e.r = r;
    exp_q.push_back(e);
  endtask

  // Counts pwm highs over one period window (samples after counter 1..P-1,0).
  task automatic measure_period(output int lc, output int rc);
    int g;
    lc = 0;
    rc = 0;
    g = 0;
    while (tb_cnt != 1 && g < 3 * P) begin
      @(negedge clk);
      g++;
    end
    for (int i = 0; i < P; i++) begin
      lc += int'(left_pwm);
      rc += int'(right_pwm);
      @(negedge clk);
    end
  endtask

  task automatic brake_seq(input logic [3:0] stop_code, input logic [3:0] mid_dir,
                           output int lat, output int len, output logic [7:0] pre,
                           output logic [7:0] at_brake, output logic [7:0] at_exit,
                           output int exit_cnt);
    dir = stop_code;
    lat = 0;
    pre = 8'h00;
    while (!braking && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) pre = obs;
    end
    at_brake = obs;
    len = 0;
    while (braking && len < 20) begin
      if (len == 1) dir = mid_dir;
      len++;
      @(negedge clk);
    end
    at_exit = obs;
    exit_cnt = tb_cnt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dir = DIR_FWD;
    repeat (3) @(negedge clk);
    total++;
    if (obs !== O_IDLE) begin
      bad++;
      $display("FAIL reset_outputs: got %b want %b", obs, O_IDLE);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== O_RUN0) begin
      bad++;
      $display("FAIL reset_release_run: got %b want %b", obs, O_RUN0);
    end
  endtask

  task automatic test_ramp();
    exp_t e;
    int lc, rc;
    push_win(0, 0);
    for (int d = STEP; d <= FULL; d += STEP) push_win(d, d);
    push_win(FULL, FULL);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure_period(lc, rc);
      total++;
      if (lc !== e.l || rc !== e.r) begin
        bad++;
        $display("FAIL ramp_window: got %0d/%0d want %0d/%0d", lc, rc, e.l, e.r);
      end
    end
    total++;
    if (obs !== O_RUN1) begin
      bad++;
      $display("FAIL ramp_full_outputs: got %b want %b", obs, O_RUN1);
    end
  endtask

  task automatic test_veer();
    exp_t e;
    int lc, rc;
    dir = DIR_LEFT;
    push_win(10, 10);
    push_win(8, 10);
    push_win(6, 10);
    push_win(4, 10);
    push_win(4, 10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure_period(lc, rc);
      total++;
      if (lc !== e.l || rc !== e.r) begin
        bad++;
        $display("FAIL veer_window: got %0d/%0d want %0d/%0d", lc, rc, e.l, e.r);
      end
    end
    total++;
    if (obs !== O_RUN1) begin
      bad++;
      $display("FAIL veer_pins: got %b want %b", obs, O_RUN1);
    end
  endtask

  task automatic test_brake();
    exp_t e;
    int lc, rc, lat, len, xc;
    logic [7:0] pre, ab, ax;
    dir = DIR_FWD;
    push_win(4, 10);
    push_win(6, 10);
    push_win(8, 10);
    push_win(10, 10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure_period(lc, rc);
      total++;
      if (lc !== e.l || rc !== e.r) begin
        bad++;
        $display("FAIL rerun_window: got %0d/%0d want %0d/%0d", lc, rc, e.l, e.r);
      end
    end
    brake_seq(DIR_STOP, DIR_STOP, lat, len, pre, ab, ax, xc);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL stop_latency: got %0d want 2", lat); end
    total++;
    if (pre !== O_RUN1) begin bad++; $display("FAIL stop_pre_edge: got %b want %b", pre, O_RUN1); end
    total++;
    if (ab !== O_BRK) begin bad++; $display("FAIL brake_outputs: got %b want %b", ab, O_BRK); end
    total++;
    if (len !== BRK) begin bad++; $display("FAIL brake_length: got %0d want %0d", len, BRK); end
    total++;
    if (ax !== O_IDLE) begin bad++; $display("FAIL brake_exit_idle: got %b want %b", ax, O_IDLE); end
    repeat (4) @(negedge clk);
    total++;
    if (obs !== O_IDLE) begin bad++; $display("FAIL stop_holds_idle: got %b want %b", obs, O_IDLE); end
  endtask

  task automatic test_brake_ignore();
    exp_t e;
    int lc, rc, lat, len, xc;
    logic [7:0] pre, ab, ax;
    dir = DIR_FWD;
    repeat (2) @(negedge clk);
    total++;
    if (obs !== O_RUN0) begin bad++; $display("FAIL idle_to_run: got %b want %b", obs, O_RUN0); end
    repeat (12) @(negedge clk);
    brake_seq(DIR_STOP, DIR_FWD, lat, len, pre, ab, ax, xc);
    total++;
    if (ab !== O_BRK) begin bad++; $display("FAIL ign_brake_outputs: got %b want %b", ab, O_BRK); end
    total++;
    if (len !== BRK) begin bad++; $display("FAIL ign_brake_length: got %0d want %0d", len, BRK); end
    total++;
    if (ax !== O_RUN0) begin bad++; $display("FAIL ign_exit_run: got %b want %b", ax, O_RUN0); end
    // Exit on a wrap edge, or just after one, leaves the first window at duty 0.
    if (xc <= 1) push_win(0, 0);
    push_win(2, 2);
    push_win(4, 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure_period(lc, rc);
      total++;
      if (lc !== e.l || rc !== e.r) begin
        bad++;
        $display("FAIL post_brake_ramp: got %0d/%0d want %0d/%0d", lc, rc, e.l, e.r);
      end
    end
  endtask

  task automatic test_illegal();
    int lat, len, xc;
    logic [7:0] pre, ab, ax;
    repeat (3) @(negedge clk);
    brake_seq(4'b0011, 4'b0011, lat, len, pre, ab, ax, xc);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL illegal_latency: got %0d want 2", lat); end
    total++;
    if (ab !== O_BRK) begin bad++; $display("FAIL illegal_brake: got %b want %b", ab, O_BRK); end
    total++;
    if (len !== BRK) begin bad++; $display("FAIL illegal_length: got %0d want %0d", len, BRK); end
    total++;
    if (ax !== O_IDLE) begin bad++; $display("FAIL illegal_exit: got %b want %b", ax, O_IDLE); end
  endtask

  task automatic test_reset_mid_brake();
    int lat;
    dir = DIR_FWD;
    repeat (7) @(negedge clk);
    dir = DIR_STOP;
    lat = 0;
    while (!braking && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 2) begin bad++; $display("FAIL mid_brake_entry: got %0d want 2", lat); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== O_IDLE) begin bad++; $display("FAIL reset_mid_brake: got %b want %b", obs, O_IDLE); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_veer();
    test_brake();
    test_brake_ignore();
    test_illegal();
    test_reset_mid_brake();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_drive_pwm.md
# motor_drive_pwm

Downstream consumer of the line-tracking direction code. Takes the 4-bit `DIR` command from the direction stage and drives two forward-only H-bridge channels (left and right wheel). Each channel has slew-limited PWM. Stop and illegal codes trigger an immediate brake interval. The block sits between the direction stage and the motor driver pins.

## Interface
- `PWM_PERIOD`, 1000: PWM period in clk cycles (25 kHz at 25 MHz).
- `FULL_DUTY`, 1000: target duty for a wheel at full speed; ≤ PWM_PERIOD.
- `SLOW_DUTY`, 400: target duty for the inner wheel while veering; ≤ FULL_DUTY.
- `RAMP_STEP`, 50: maximum duty change per PWM period.
- `BRAKE_CYCLES`, 12_500_000: brake hold length in clk cycles (500 ms).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `dir`  in  4  direction code: 0000 forward, 0101 veer left, 1001 veer right, 1111 stop; all other codes are treated as stop.
- `left_pwm`  out  1  left wheel enable PWM.
- `right_pwm`  out  1  right wheel enable PWM.
- `left_in`  out  2  left H-bridge inputs {in1,in2}: 10 forward, 11 brake, 00 coast.
- `right_in`  out  2  right H-bridge inputs, same encoding as `left_in`.
- `braking`  out  1  high while in BRAKE.
- `moving`  out  1  high while in RUN.

## Operation
- Input register: `dir` is sampled into `dir_q` every cycle. All decisions use `dir_q`.
- Target decode from `dir_q` (left/right):
  - forward: FULL/FULL.
  - veer left: SLOW/FULL.
  - veer right: FULL/SLOW.
  - stop or illegal: stop request.
- Targets are latched only at period wrap, i.e. the cycle where `cnt == PWM_PERIOD-1`.
- Period counter: `cnt` counts 0..PWM_PERIOD-1 and wraps. It is shared by both channels and free-runs in every state.
- Duty register per channel, width `$clog2(PWM_PERIOD+1)`. It updates only at wrap:
  - if duty < target: duty = min(duty+RAMP_STEP, target).
  - if duty > target: duty = max(duty−RAMP_STEP, target), saturating, never below 0.
- PWM output: `pwm = (cnt < duty)`, registered. Duty 0 gives constant low. Duty PWM_PERIOD gives constant high.
- FSM states are IDLE, RUN, BRAKE.
  - IDLE: duties 0, pins 00, pwm 0. A drive code in `dir_q` moves to RUN; the duty ramp starts at the next wrap. A stop code stays in IDLE.
  - RUN: pins 10, duties ramp toward targets. A stop or illegal code in `dir_q` moves to BRAKE on the next edge. On that edge duties are forced to 0 without waiting for wrap, pins go to 11, and the brake counter loads BRAKE_CYCLES−1.
  - BRAKE: pins 11, pwm 0, counter decrements each cycle. `dir_q` is ignored until the counter reaches 0. At 0 the next state is RUN if `dir_q` is a drive code, otherwise IDLE. Duty restarts from 0.
- Reset (`rst_n` low on an edge), from any state including mid-ramp and mid-brake:
  - state IDLE; `cnt`, duties, brake counter and `dir_q` cleared.
  - all outputs 0: pwm 0, pins 00, `braking` 0, `moving` 0.

## Timing
- `dir` change at edge k is seen in `dir_q` after edge k; a stop takes effect on outputs after edge k+1, i.e. 2-cycle stop latency.
- A drive-code change takes effect at the first wrap after `dir_q` updates. Worst case is PWM_PERIOD+1 cycles to the first duty step.
- Ramp from 0 to FULL takes ceil(FULL_DUTY/RAMP_STEP) periods.
- The brake interval is exactly BRAKE_CYCLES cycles with `braking` high.
- If a stop and a wrap occur in the same cycle, the stop wins: duty is 0 and no ramp step is applied.
- No combinational path from `dir` to any output. All outputs are registered.

## Structure
- `motor_pkg`: state enum {IDLE, RUN, BRAKE}; DIR code constants DIR_FWD=0000, DIR_LEFT=0101, DIR_RIGHT=1001, DIR_STOP=1111; pin codes PIN_FWD=10, PIN_BRAKE=11, PIN_COAST=00.
- One sub-module, `pwm_channel`, instantiated twice (left, right). It holds the duty register, ramp logic and compare, with inputs `cnt`, `wrap`, `target`, `force_zero`.
- The top level owns `dir_q`, decode, FSM, the shared `cnt` and the brake counter.

## Test plan
All scenarios use PWM_PERIOD=10, FULL=10, SLOW=4, RAMP_STEP=2, BRAKE_CYCLES=5.
- Reset: hold `rst_n` low 3 cycles with `dir`=0000 → all outputs 0 and IDLE; after release, RUN within 2 cycles, pins 10, first duty step at the next wrap.
- Ramp up: `dir`=0000 from IDLE → per-period high counts 2, 4, 6, 8, 10 on both wheels, then constant high; `moving`=1.
- Veer: at full speed set `dir`=0101 → left high counts 8, 6, 4 then hold at 4; right stays 10; pins stay 10.
- Brake: at full speed set `dir`=1111 → 2 cycles later both pwm 0, pins 11, `braking`=1 for exactly 5 cycles, then IDLE with pins 00. Also set `dir`=0000 during the brake → it is ignored until expiry, then RUN and ramp from 2.
- Illegal code: `dir`=0011 in RUN → identical response to 1111.
- Reset mid-brake: `rst_n` low at brake cycle 2 → IDLE on the next edge, all outputs 0, `braking`=0.
